// File: rtl/register_write_scheduler_pkg.sv
// Shared types for the synth register bus: the {number, value} write record,
// KeyOn decoding and the issue FSM state encoding.
package synth_bus_pkg;

    typedef struct packed {
        logic [15:0] Number;
        logic [15:0] Value;
    } RegisterWrite_t;

    localparam logic [7:0] KEYON_OFFSET = 8'h00;
    localparam logic [4:0] VOICE_FIRST  = 5'd1;
    localparam logic [4:0] VOICE_LAST   = 5'd16;

    typedef enum logic {
        ISSUE_IDLE       = 1'b0,
        ISSUE_HOLD_KEYON = 1'b1
    } issue_state_e;

    // Voice lives in Number[15:11]; operator field 0 and offset 0x00 select KeyOn.
    function automatic logic is_keyon(input RegisterWrite_t w);
        logic [4:0] voice;
        voice = w.Number[15:11];
        return (voice >= VOICE_FIRST) && (voice <= VOICE_LAST) &&
               (w.Number[10:8] == 3'd0) && (w.Number[7:0] == KEYON_OFFSET);
    endfunction

endpackage

// File: rtl/register_write_scheduler_if.sv
// Write bus from the scheduler into the synth register file, plus the issue
// FSM state for observation.
//
// Handshake: strobe-only, no back-pressure. The synth takes one write on every
// cycle o_RegisterWriteEnable is high; number/value are valid in that cycle and
// hold their last value otherwise.
interface register_write_scheduler_if;
    import synth_bus_pkg::*;

    logic         o_RegisterWriteEnable;
    logic [15:0]  o_RegisterNumber;
    logic [15:0]  o_RegisterValue;
    issue_state_e o_IssueState;

    modport master (
        output o_RegisterWriteEnable,
        output o_RegisterNumber,
        output o_RegisterValue,
        output o_IssueState
    );

    modport slave (
        input o_RegisterWriteEnable,
        input o_RegisterNumber,
        input o_RegisterValue,
        input o_IssueState
    );

endinterface

// File: rtl/register_write_scheduler_fifo.sv
// Synchronous FIFO of register writes; the head is the registered entry at the
// read pointer, so pop decisions never depend on this cycle's push.
module register_write_fifo
    import synth_bus_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    input  logic           i_Push,
    input  RegisterWrite_t i_PushData,
    input  logic           i_Pop,
    output RegisterWrite_t o_Head,
    output logic           o_Full,
    output logic           o_Empty,
    output logic [CW-1:0]  o_Count
);

    RegisterWrite_t mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok;
    logic           pop_ok;

    assign o_Full  = (count_q == CW'(DEPTH));
    assign o_Empty = (count_q == '0);
    assign o_Count = count_q;
    assign o_Head  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = i_Pop && !o_Empty;
    assign push_ok = i_Push && (!o_Full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_PushData;
        end
    end

endmodule

// File: rtl/register_write_scheduler.sv
// SPI front end for the synth register bus: assembles 32-bit write frames,
// queues them and issues them in order, holding KeyOn writes to a sample edge.
module register_write_scheduler
    import synth_bus_pkg::*;
#(
    parameter int  FIFO_DEPTH  = 8,
    parameter int  DEFER_KEYON = 1,
    localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_SpiClock,
    input  logic                  i_SpiChipSelect_n,
    input  logic                  i_SpiMosi,
    input  logic                  i_SampleReady,
    register_write_scheduler_if.master reg_bus,
    output logic [LEVEL_W-1:0]    o_FifoLevel,
    output logic                  o_Overflow
);

    logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

    logic [31:0]  shift_q, shift_d;
    logic [4:0]   bit_cnt_q, bit_cnt_d;
    logic [31:0]  frame_word;
    logic         sck_rise;
    logic         frame_push;

    issue_state_e state_q, state_d;
    logic         strobe_q, strobe_d;
    logic [15:0]  number_q, number_d;
    logic [15:0]  value_q, value_d;
    logic         overflow_q, overflow_d;

    RegisterWrite_t     fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [LEVEL_W-1:0] fifo_count;
    logic               head_is_keyon;

    register_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Push     (frame_push),
        .i_PushData (RegisterWrite_t'(frame_word)),
        .i_Pop      (fifo_pop),
        .o_Head     (fifo_head),
        .o_Full     (fifo_full),
        .o_Empty    (fifo_empty),
        .o_Count    (fifo_count)
    );

    // SPI receive: every SPI input is resynchronised before use, and a frame
    // is pushed in the same cycle its 32nd bit is shifted.
    always_comb begin
        sck_meta_d  = i_SpiClock;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        cs_meta_d   = i_SpiChipSelect_n;
        cs_sync_d   = cs_meta_q;
        mosi_meta_d = i_SpiMosi;
        mosi_sync_d = mosi_meta_q;

        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        frame_push = 1'b0;
        frame_word = {shift_q[30:0], mosi_sync_q};
        sck_rise   = sck_sync_q && !sck_prev_q && !cs_sync_q;

        if (cs_sync_q) begin
            bit_cnt_d = '0;
        end else if (sck_rise) begin
            shift_d    = frame_word;
            bit_cnt_d  = bit_cnt_q + 5'd1;
            frame_push = (bit_cnt_q == 5'd31);
        end
    end

    assign head_is_keyon = (DEFER_KEYON != 0) && is_keyon(fifo_head);

    // Issue FSM: a KeyOn at the head blocks everything behind it until a
    // sample pulse arrives after the FSM has entered HOLD_KEYON.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ISSUE_IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_keyon) begin
                        state_d = ISSUE_HOLD_KEYON;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            ISSUE_HOLD_KEYON: begin
                if (i_SampleReady) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE_IDLE;
                end
            end
            default: state_d = ISSUE_IDLE;
        endcase

        strobe_d   = fifo_pop;
        number_d   = fifo_pop ? fifo_head.Number : number_q;
        value_d    = fifo_pop ? fifo_head.Value  : value_q;
        overflow_d = overflow_q || (frame_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            state_q     <= ISSUE_IDLE;
            strobe_q    <= 1'b0;
            number_q    <= '0;
            value_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            number_q    <= number_d;
            value_q     <= value_d;
            overflow_q  <= overflow_d;
        end
    end

    assign reg_bus.o_RegisterWriteEnable = strobe_q;
    assign reg_bus.o_RegisterNumber      = number_q;
    assign reg_bus.o_RegisterValue       = value_q;
    assign reg_bus.o_IssueState          = state_q;
    assign o_FifoLevel                   = fifo_count;
    assign o_Overflow                    = overflow_q;

endmodule

// File: tb/tb_register_write_scheduler.sv
// Bench for register_write_scheduler: two instances (KeyOn deferred / not)
// share one SPI stream and are checked every cycle against a queue model.
module tb_register_write_scheduler;
    import synth_bus_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic srdy_dir = 1'b0, srdy_rand = 1'b0;
    logic srdy;
    assign srdy = srdy_dir | srdy_rand;

    register_write_scheduler_if bus0 ();
    register_write_scheduler_if bus1 ();
    logic [LW-1:0] lvl0, lvl1;
    logic          ovf0, ovf1;

    register_write_scheduler #(.FIFO_DEPTH(DEPTH), .DEFER_KEYON(1)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_SpiClock(sck), .i_SpiChipSelect_n(cs_n),
        .i_SpiMosi(mosi), .i_SampleReady(srdy), .reg_bus(bus0),
        .o_FifoLevel(lvl0), .o_Overflow(ovf0));

    register_write_scheduler #(.FIFO_DEPTH(DEPTH), .DEFER_KEYON(0)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_SpiClock(sck), .i_SpiChipSelect_n(cs_n),
        .i_SpiMosi(mosi), .i_SampleReady(srdy), .reg_bus(bus1),
        .o_FifoLevel(lvl1), .o_Overflow(ovf1));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic                   sck1, sck2, sck3, cs1, cs2, mosi1, mosi2;
        logic [31:0]            sr;
        logic [4:0]             cnt;
        logic [DEPTH-1:0][31:0] q;
        logic [LW-1:0]          n;
        logic                   hold;
        logic                   stb;
        logic [31:0]            last;
        logic                   ovf;
    } model_t;

    model_t m0, m1;
    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;
    bit rand_sr_en = 1'b0;
    logic [31:0] log0[$];
    logic [31:0] log1[$];

    function automatic bit model_keyon(input logic [31:0] w);
        int voice;
        voice = int'(w[31:27]);
        return (voice >= 1) && (voice <= 16) && (w[26:16] == 11'd0);
    endfunction

    function automatic model_t model_step(input model_t m, input bit defer, input logic reset,
                                          input logic sck_in, input logic cs_in,
                                          input logic mosi_in, input logic sr_in);
        model_t r;
        bit edge_seen, pop;
        logic [31:0] word;
        r = m;
        if (reset) begin
            r = '0;
            r.cs1 = 1'b1;
            r.cs2 = 1'b1;
            return r;
        end
        edge_seen = m.sck2 && !m.sck3 && !m.cs2;
        pop = 1'b0;
        if (m.n != 0) begin
            if (!m.hold) begin
                if (defer && model_keyon(m.q[0])) r.hold = 1'b1;
                else pop = 1'b1;
            end else if (sr_in) begin
                pop = 1'b1;
                r.hold = 1'b0;
            end
        end
        r.stb = pop;
        if (pop) begin
            r.last = m.q[0];
            for (int i = 0; i < DEPTH - 1; i++) r.q[i] = m.q[i+1];
            r.n = m.n - LW'(1);
        end
        if (m.cs2) begin
            r.cnt = 5'd0;
        end else if (edge_seen) begin
            word  = {m.sr[30:0], m.mosi2};
            r.sr  = word;
            r.cnt = m.cnt + 5'd1;
            if (m.cnt == 5'd31) begin
                if (int'(r.n) < DEPTH) begin
                    r.q[r.n] = word;
                    r.n = r.n + LW'(1);
                end else begin
                    r.ovf = 1'b1;
                end
            end
        end
        r.sck1 = sck_in;  r.sck2 = m.sck1;  r.sck3 = m.sck2;
        r.cs1  = cs_in;   r.cs2  = m.cs1;
        r.mosi1 = mosi_in; r.mosi2 = m.mosi1;
        return r;
    endfunction

    always @(posedge clk) begin
        m0 = model_step(m0, 1'b1, rst, sck, cs_n, mosi, srdy);
        m1 = model_step(m1, 1'b0, rst, sck, cs_n, mosi, srdy);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stb0",   32'(bus0.o_RegisterWriteEnable), 32'(m0.stb));
            check("bus0",   {bus0.o_RegisterNumber, bus0.o_RegisterValue}, m0.last);
            check("level0", 32'(lvl0), 32'(m0.n));
            check("ovf0",   32'(ovf0), 32'(m0.ovf));
            check("hold0",  32'(bus0.o_IssueState == ISSUE_HOLD_KEYON), 32'(m0.hold));
            check("stb1",   32'(bus1.o_RegisterWriteEnable), 32'(m1.stb));
            check("bus1",   {bus1.o_RegisterNumber, bus1.o_RegisterValue}, m1.last);
            check("level1", 32'(lvl1), 32'(m1.n));
            check("ovf1",   32'(ovf1), 32'(m1.ovf));
            check("hold1",  32'(bus1.o_IssueState == ISSUE_HOLD_KEYON), 32'(m1.hold));
            if (bus0.o_RegisterWriteEnable === 1'b1)
                log0.push_back({bus0.o_RegisterNumber, bus0.o_RegisterValue});
            if (bus1.o_RegisterWriteEnable === 1'b1)
                log1.push_back({bus1.o_RegisterNumber, bus1.o_RegisterValue});
        end
    end

    always @(negedge clk) srdy_rand = rand_sr_en && ($urandom_range(0, 15) == 0);

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, input int half);
        mosi = b;
        idle(half);
        sck = 1'b1;
        idle(half);
        sck = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] w, input int nbits, input int half);
        for (int i = 31; i > 31 - nbits; i--) spi_bit(w[i], half);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        idle(3);
    endtask

    task automatic cs_high();
        idle(3);
        cs_n = 1'b1;
        idle(3);
    endtask

    task automatic send_frame(input logic [31:0] w);
        cs_low();
        spi_bits(w, 32, 3);
        cs_high();
    endtask

    task automatic pulse_sr();
        srdy_dir = 1'b1;
        @(negedge clk);
        srdy_dir = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        log0.delete();
        log1.delete();
        idle(1);
    endtask

    function automatic logic [31:0] log_at(input int which, input int idx);
        if (which == 0) return (idx < log0.size()) ? log0[idx] : 32'hDEAD_DEAD;
        return (idx < log1.size()) ? log1[idx] : 32'hDEAD_DEAD;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle(3);
        chk_en = 1'b1;
        check("reset_level0", 32'(lvl0), 32'd0);
        check("reset_stb0",   32'(bus0.o_RegisterWriteEnable), 32'd0);
        check("reset_ovf0",   32'(ovf0), 32'd0);
        check("reset_bus0",   {bus0.o_RegisterNumber, bus0.o_RegisterValue}, 32'd0);
        rst = 1'b0;
        idle(2);

        // single frame
        send_frame(32'h0810_1234);
        idle(6);
        check("single_count0", 32'(log0.size()), 32'd1);
        check("single_word0",  log_at(0, 0), 32'h0810_1234);
        check("single_word1",  log_at(1, 0), 32'h0810_1234);
        check("single_level0", 32'(lvl0), 32'd0);

        // three-frame burst under one chip select
        cs_low();
        spi_bits(32'h0811_0001, 32, 3);
        spi_bits(32'h0812_0002, 32, 4);
        spi_bits(32'h0813_0003, 32, 3);
        cs_high();
        idle(6);
        check("burst_count0", 32'(log0.size()), 32'd4);
        check("burst_w1",     log_at(0, 1), 32'h0811_0001);
        check("burst_w2",     log_at(0, 2), 32'h0812_0002);
        check("burst_w3",     log_at(0, 3), 32'h0813_0003);

        // KeyOn held until a sample pulse
        do_reset();
        cs_low();
        spi_bits(32'h0800_0001, 32, 3);
        spi_bits(32'h0901_0055, 32, 3);
        cs_high();
        idle(10);
        check("keyon_level0", 32'(lvl0), 32'd2);
        check("keyon_none0",  32'(log0.size()), 32'd0);
        check("keyon_hold0",  32'(bus0.o_IssueState == ISSUE_HOLD_KEYON), 32'd1);
        check("nodefer_cnt1", 32'(log1.size()), 32'd2);
        check("nodefer_w0",   log_at(1, 0), 32'h0800_0001);
        check("nodefer_w1",   log_at(1, 1), 32'h0901_0055);
        pulse_sr();
        idle(5);
        check("keyon_cnt0",   32'(log0.size()), 32'd2);
        check("keyon_w0",     log_at(0, 0), 32'h0800_0001);
        check("keyon_w1",     log_at(0, 1), 32'h0901_0055);
        check("nodefer_ign1", 32'(log1.size()), 32'd2);

        // overflow behind a held KeyOn
        do_reset();
        cs_low();
        spi_bits(32'h0800_0001, 32, 3);
        for (int i = 1; i <= 9; i++) spi_bits({16'h2000 + 16'(i), 16'(i)}, 32, 3);
        cs_high();
        idle(10);
        check("ovf_level0",  32'(lvl0), 32'd8);
        check("ovf_flag0",   32'(ovf0), 32'd1);
        check("ovf_flag1",   32'(ovf1), 32'd0);
        check("ovf_drain1",  32'(log1.size()), 32'd10);
        pulse_sr();
        idle(15);
        check("ovf_cnt0",    32'(log0.size()), 32'd8);
        check("ovf_first0",  log_at(0, 0), 32'h0800_0001);
        check("ovf_last0",   log_at(0, 7), 32'h2007_0007);
        check("ovf_empty0",  32'(lvl0), 32'd0);

        // partial frame discarded by CS deassert
        do_reset();
        cs_low();
        spi_bits(32'hFFFF_FFFF, 17, 3);
        cs_high();
        send_frame(32'h1000_00AA);
        idle(6);
        pulse_sr();
        idle(5);
        check("partial_cnt0", 32'(log0.size()), 32'd1);
        check("partial_w0",   log_at(0, 0), 32'h1000_00AA);
        check("partial_cnt1", 32'(log1.size()), 32'd1);
        check("partial_ovf0", 32'(ovf0), 32'd0);

        // reset while holding a KeyOn
        do_reset();
        cs_low();
        spi_bits(32'h0800_0001, 32, 3);
        spi_bits(32'h2100_0001, 32, 3);
        spi_bits(32'h2200_0002, 32, 3);
        cs_high();
        idle(6);
        check("rsth_level0", 32'(lvl0), 32'd3);
        check("rsth_hold0",  32'(bus0.o_IssueState == ISSUE_HOLD_KEYON), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rsth_lvl_after",   32'(lvl0), 32'd0);
        check("rsth_stb_after",   32'(bus0.o_RegisterWriteEnable), 32'd0);
        check("rsth_state_after", 32'(bus0.o_IssueState == ISSUE_HOLD_KEYON), 32'd0);
        rst = 1'b0;
        idle(2);

        // randomized traffic
        do_reset();
        rand_sr_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int burst;
            int half;
            bit aborted;
            logic [31:0] w;
            burst   = $urandom_range(1, 3);
            half    = $urandom_range(3, 6);
            aborted = 1'b0;
            cs_low();
            for (int b = 0; b < burst; b++) begin
                if (!aborted) begin
                    w = $urandom;
                    if ($urandom_range(0, 3) == 0) w[31:16] = {5'($urandom_range(1, 16)), 11'd0};
                    if ($urandom_range(0, 9) == 0) begin
                        spi_bits(w, $urandom_range(1, 31), half);
                        aborted = 1'b1;
                    end else begin
                        spi_bits(w, 32, half);
                    end
                end
            end
            cs_high();
            idle($urandom_range(0, 20));
        end
        idle(40);
        rand_sr_en = 1'b0;
        repeat (10) begin
            pulse_sr();
            idle(3);
        end
        check("rand_final_level0", 32'(lvl0), 32'd0);
        check("rand_final_level1", 32'(lvl1), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
